// File: rtl/sfm_pkg.sv
// Shared softmax types and constants; carries the expu pipeline-controller
// tag type and default register count.
package sfm_pkg;

    localparam int unsigned EXPU_CTRL_DEFAULT_NUM_REGS = 3;
    localparam int unsigned EXPU_CTRL_TAG_WIDTH        = 4;

    typedef logic [EXPU_CTRL_TAG_WIDTH-1:0] expu_ctrl_tag_t;

endpackage : sfm_pkg

// File: rtl/expu_pipe_stage.sv
// One handshake stage of the expu controller: valid/tag flop plus the
// ready and load-enable terms for the register it shadows.
module expu_pipe_stage #(
    parameter int unsigned TAG_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 in_v_i,
    input  logic [TAG_WIDTH-1:0] in_t_i,
    input  logic                 rdy_next_i,
    output logic                 rdy_o,
    output logic                 en_o,
    output logic                 v_o,
    output logic [TAG_WIDTH-1:0] tag_o
);

    logic                 v_q;
    logic [TAG_WIDTH-1:0] tag_q;

    // An empty stage accepts even when everything downstream is stalled.
    assign rdy_o = ~v_q | rdy_next_i;
    assign en_o  = in_v_i & rdy_o & ~clear_i;
    assign v_o   = v_q;
    assign tag_o = tag_q;

    // Stage state: flush on clear, otherwise advance whenever ready.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q   <= 1'b0;
            tag_q <= {TAG_WIDTH{1'b0}};
        end else if (clear_i) begin
            v_q   <= 1'b0;
            tag_q <= {TAG_WIDTH{1'b0}};
        end else if (rdy_o) begin
            v_q <= in_v_i;
            if (in_v_i) begin
                tag_q <= in_t_i;
            end else begin
                tag_q <= tag_q;
            end
        end else begin
            v_q   <= v_q;
            tag_q <= tag_q;
        end
    end

endmodule : expu_pipe_stage

// File: rtl/expu_pipe_ctrl.sv
// Valid/ready controller for the expu register row: per-register enables,
// flush strobe, bubble collapse. Define EXPU_PIPE_CTRL_PERF_EN for the stall counter.
module expu_pipe_ctrl
    import sfm_pkg::*;
#(
    parameter  int unsigned NUM_REGS  = EXPU_CTRL_DEFAULT_NUM_REGS,
    parameter  int unsigned TAG_WIDTH = 4,
    localparam int unsigned CNT_WIDTH = $clog2(NUM_REGS + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [TAG_WIDTH-1:0] tag_i,
    output logic [NUM_REGS-1:0]  enable_o,
    output logic                 clear_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [TAG_WIDTH-1:0] tag_o,
    output logic [CNT_WIDTH-1:0] inflight_o,
    output logic                 busy_o,
    output logic [31:0]          perf_stall_o
);

    if (NUM_REGS < 1) begin : g_cfg_check
        $error("expu_pipe_ctrl: NUM_REGS must be at least 1");
    end

    // Index i feeds stage i; index NUM_REGS is the row output.
    logic [NUM_REGS:0]    in_v_s;
    logic [TAG_WIDTH-1:0] in_t_s [NUM_REGS+1];
    logic [NUM_REGS:0]    rdy_s;
    logic                 accept_s;
    logic                 pop_s;
    logic [CNT_WIDTH-1:0] inflight_q;

    assign in_v_s[0]        = valid_i;
    assign in_t_s[0]        = tag_i;
    assign rdy_s[NUM_REGS]  = ready_i;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_stage
        expu_pipe_stage #(
            .TAG_WIDTH (TAG_WIDTH)
        ) u_stage (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .clear_i    (clear_i),
            .in_v_i     (in_v_s[i]),
            .in_t_i     (in_t_s[i]),
            .rdy_next_i (rdy_s[i+1]),
            .rdy_o      (rdy_s[i]),
            .en_o       (enable_o[i]),
            .v_o        (in_v_s[i+1]),
            .tag_o      (in_t_s[i+1])
        );
    end

    assign ready_o    = rdy_s[0] & ~clear_i;
    assign clear_o    = clear_i;
    assign valid_o    = in_v_s[NUM_REGS];
    assign tag_o      = in_t_s[NUM_REGS];
    assign accept_s   = valid_i & ready_o;
    assign pop_s      = valid_o & ready_i;
    assign inflight_o = inflight_q;
    assign busy_o     = (inflight_q != {CNT_WIDTH{1'b0}});

    // In-flight count; a simultaneous accept and pop leaves it unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= {CNT_WIDTH{1'b0}};
        end else if (clear_i) begin
            inflight_q <= {CNT_WIDTH{1'b0}};
        end else if (accept_s && !pop_s) begin
            inflight_q <= inflight_q + CNT_WIDTH'(1);
        end else if (!accept_s && pop_s) begin
            inflight_q <= inflight_q - CNT_WIDTH'(1);
        end else begin
            inflight_q <= inflight_q;
        end
    end

`ifdef EXPU_PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q;

    // Saturating count of cycles where a result waits on the downstream.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_stall_q <= 32'd0;
        end else if (clear_i) begin
            perf_stall_q <= 32'd0;
        end else if (valid_o && !ready_i && (perf_stall_q != 32'hFFFF_FFFF)) begin
            perf_stall_q <= perf_stall_q + 32'd1;
        end else begin
            perf_stall_q <= perf_stall_q;
        end
    end

    assign perf_stall_o = perf_stall_q;
`else
    assign perf_stall_o = 32'd0;
`endif

endmodule : expu_pipe_ctrl

// File: tb/tb_expu_pipe_ctrl.sv
// Self-checking bench for expu_pipe_ctrl: directed test-plan steps followed by
// random traffic, compared against a slot-occupancy reference model.
module tb_expu_pipe_ctrl;

    localparam int N  = 3;
    localparam int TW = 4;
    localparam int CW = $clog2(N + 1);

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          clear_i;
    logic          valid_i;
    logic          ready_o;
    logic [TW-1:0] tag_i;
    logic [N-1:0]  enable_o;
    logic          clear_o;
    logic          valid_o;
    logic          ready_i;
    logic [TW-1:0] tag_o;
    logic [CW-1:0] inflight_o;
    logic          busy_o;
    logic [31:0]   perf_stall_o;

    expu_pipe_ctrl #(
        .NUM_REGS  (N),
        .TAG_WIDTH (TW)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (clear_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .tag_i        (tag_i),
        .enable_o     (enable_o),
        .clear_o      (clear_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .tag_o        (tag_o),
        .inflight_o   (inflight_o),
        .busy_o       (busy_o),
        .perf_stall_o (perf_stall_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    // Reference: slot k holds the item sitting in expu register k+1.
    bit          m_v [N];
    logic [TW-1:0] m_t [N];
    longint      m_perf;
    int          m_popped;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_v[k] = 1'b0;
            m_t[k] = '0;
        end
        m_perf = 0;
    endtask

    // One cycle: drive inputs at negedge, check against model, advance at posedge.
    task automatic step(input bit v, input logic [TW-1:0] t, input bit r, input bit c);
        bit   moves [N];
        bit   out;
        bit   leaves;
        bit   rdy0;
        int   cnt;
        logic [N-1:0] en_exp;
        bit   nv [N];
        logic [TW-1:0] nt [N];

        valid_i = v; tag_i = t; ready_i = r; clear_i = c;
        #1;
        for (int k = 0; k < N; k++) moves[k] = 1'b0;
        out  = 1'b0;
        rdy0 = 1'b0;
        if (!c) begin
            out    = m_v[N-1] && r;
            leaves = out;
            for (int k = N - 1; k >= 1; k--) begin
                moves[k] = m_v[k-1] && (!m_v[k] || leaves);
                leaves   = moves[k];
            end
            rdy0     = !m_v[0] || leaves;
            moves[0] = v && rdy0;
        end
        cnt = 0;
        for (int k = 0; k < N; k++) begin
            cnt += m_v[k] ? 1 : 0;
            en_exp[k] = moves[k];
        end

        chk("ready_o",    32'(ready_o),    32'(rdy0));
        chk("enable_o",   32'(enable_o),   32'(en_exp));
        chk("clear_o",    32'(clear_o),    32'(c));
        chk("valid_o",    32'(valid_o),    32'(m_v[N-1]));
        chk("tag_o",      32'(tag_o),      32'(m_t[N-1]));
        chk("inflight_o", 32'(inflight_o), 32'(cnt));
        chk("busy_o",     32'(busy_o),     32'(cnt != 0));
        chk("perf_stall", perf_stall_o,    32'(m_perf));

        @(posedge clk_i);
        if (c) begin
            model_reset();
        end else begin
            if (out) m_popped++;
            for (int k = 0; k < N; k++) begin
                nt[k] = m_t[k];
                if (moves[k]) begin
                    nv[k] = 1'b1;
                    nt[k] = (k == 0) ? t : m_t[k-1];
                end else begin
                    nv[k] = m_v[k] && !((k == N - 1) ? out : moves[k+1]);
                end
            end
            for (int k = 0; k < N; k++) begin
                m_v[k] = nv[k];
                m_t[k] = nt[k];
            end
`ifdef EXPU_PIPE_CTRL_PERF_EN
            if (m_v[N-1] === 1'b0) begin
            end
`endif
        end
        @(negedge clk_i);
    endtask

    // Stall accounting is evaluated on pre-edge state, so track it separately.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_perf <= 0;
        end else begin
`ifdef EXPU_PIPE_CTRL_PERF_EN
            if (clear_i) m_perf <= 0;
            else if (valid_o === 1'b1 && ready_i === 1'b0 && m_perf < 64'hFFFF_FFFF) m_perf <= m_perf + 1;
`else
            m_perf <= 0;
`endif
        end
    end

    initial begin
        logic [TW-1:0] rt;
        rst_ni = 1'b0; clear_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; tag_i = '0;
        m_popped = 0;
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        chk("reset_ready_o", 32'(ready_o), 32'd1);
        chk("reset_inflight", 32'(inflight_o), 32'd0);

        // Streaming at full throughput: tags 1..4 then drain.
        for (int k = 1; k <= 4; k++) step(1'b1, TW'(k), 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 4'h0, 1'b1, 1'b0);

        // Backpressure: five pushes, only three accepted.
        for (int k = 0; k < 5; k++) step(1'b1, TW'(k + 5), 1'b0, 1'b0);
        chk("bp_inflight_full", 32'(inflight_o), 32'(N));
        chk("bp_ready_low", 32'(ready_o), 32'd0);
        for (int k = 0; k < 4; k++) step(1'b0, 4'h0, 1'b1, 1'b0);

        // Bubble collapse under a stalled output.
        step(1'b1, 4'hA, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b0, 1'b0);
        step(1'b1, 4'hB, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 4'h0, 1'b0, 1'b0);
        chk("bubble_inflight", 32'(inflight_o), 32'd2);
        chk("bubble_valid_o", 32'(valid_o), 32'd1);

        // Long stall for the perf counter (output stays valid, ready low).
        for (int k = 0; k < 10; k++) step(1'b0, 4'h0, 1'b0, 1'b0);

        // Clear with two in flight and an input offered.
        step(1'b1, 4'hC, 1'b0, 1'b1);
        chk("post_clear_inflight", 32'(inflight_o), 32'd0);
        step(1'b0, 4'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-stream, then a single item after release.
        step(1'b1, 4'h3, 1'b1, 1'b0);
        step(1'b1, 4'h4, 1'b1, 1'b0);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_rst_valid_o", 32'(valid_o), 32'd0);
        chk("async_rst_inflight", 32'(inflight_o), 32'd0);
        chk("async_rst_tag_o", 32'(tag_o), 32'd0);
        chk("async_rst_perf", perf_stall_o, 32'd0);
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        step(1'b1, 4'h9, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 4'h0, 1'b1, 1'b0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rt = TW'($urandom_range(15, 0));
            step($urandom_range(9, 0) < 7, rt, $urandom_range(9, 0) < 6, $urandom_range(39, 0) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_expu_pipe_ctrl
